audio_pwm_out: RTL and testbench



---
 rtl/tone_gen_pkg.sv | 11 +
 rtl/pwm_duty_quantizer.sv | 41 ++++
 rtl/audio_pwm_out.sv | 136 +++++++++++++
 tb/tb_audio_pwm_out.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tone_gen_pkg.sv
// Shared tone-generator definitions: sample width, offset-binary constant and PWM output FSM states.
// Used by the DDS mixer and by audio_pwm_out.
package tone_gen_pkg;
  localparam int SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    RUN        = 1'b1
  } pwm_state_e;
endpackage

// File: rtl/pwm_duty_quantizer.sv
// Combinational sample-to-duty conversion: offset binary, then truncation to PWM_BITS.
// `PWM_NOISE_SHAPE_EN adds first-order error feedback with saturation.
module pwm_duty_quantizer
  import tone_gen_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int ERR_W    = SAMPLE_W - PWM_BITS
) (
  input  logic [SAMPLE_W-1:0] source,
`ifdef PWM_NOISE_SHAPE_EN
  input  logic [ERR_W-1:0]    err,
  output logic [ERR_W-1:0]    err_next,
`endif
  output logic [PWM_BITS-1:0] duty
);

  logic [SAMPLE_W-1:0] ob_s;

`ifdef PWM_NOISE_SHAPE_EN
  logic [SAMPLE_W:0] sum_s;

  // Fold the previous residue back in; a carry out saturates rather than wrapping to zero.
  always_comb begin
    ob_s     = source ^ MIDSCALE;
    sum_s    = {1'b0, ob_s} + {{(PWM_BITS + 1){1'b0}}, err};
    err_next = sum_s[ERR_W-1:0];
    if (sum_s[SAMPLE_W]) begin
      duty = {PWM_BITS{1'b1}};
    end else begin
      duty = sum_s[SAMPLE_W-1 -: PWM_BITS];
    end
  end
`else
  // Plain truncation of the offset-binary sample.
  always_comb begin
    ob_s = source ^ MIDSCALE;
    duty = PWM_BITS'(ob_s >> ERR_W);
  end
`endif

endmodule

// File: rtl/audio_pwm_out.sv
// Audio PWM output stage: captures mixed samples, double-buffers the duty and drives one PWM pin.
// Optional first-order noise shaping is enabled with `PWM_NOISE_SHAPE_EN.
module audio_pwm_out
  import tone_gen_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic [SAMPLE_W-1:0] data_in,
  input  logic                data_valid_in,
  output logic                pwm_out,
  output logic                sample_taken_out,
  output logic                overrun_out
);

  localparam int ERR_W = SAMPLE_W - PWM_BITS;
  localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS - 1){1'b0}}};

  logic [PWM_BITS-1:0] cnt_r, cnt_next_s;
  logic [PWM_BITS-1:0] duty_r, duty_next_s, q_duty_s;
  logic [SAMPLE_W-1:0] pend_r, source_s;
  logic                pend_vld_r;
  logic                boundary_s, load_s;
  logic                pwm_r, pwm_next_s, sample_taken_r, overrun_r;
  pwm_state_e          state_r, state_next_s;

  // Boundary detection and load source selection; a coincident strobe bypasses the pending slot.
  always_comb begin
    cnt_next_s = cnt_r + {{(PWM_BITS - 1){1'b0}}, 1'b1};
    boundary_s = &cnt_r;
    load_s     = boundary_s && (pend_vld_r || data_valid_in);
    if (data_valid_in) begin
      source_s = data_in;
    end else begin
      source_s = pend_r;
    end
    if (load_s) begin
      duty_next_s = q_duty_s;
    end else begin
      duty_next_s = duty_r;
    end
  end

`ifdef PWM_NOISE_SHAPE_EN
  logic [ERR_W-1:0] err_r, err_next_s;

  pwm_duty_quantizer #(.PWM_BITS(PWM_BITS)) u_quant (
    .source   (source_s),
    .err      (err_r),
    .err_next (err_next_s),
    .duty     (q_duty_s)
  );

  // Residue only advances when a sample is actually loaded.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      err_r <= {ERR_W{1'b0}};
    end else if (load_s) begin
      err_r <= err_next_s;
    end
  end
`else
  pwm_duty_quantizer #(.PWM_BITS(PWM_BITS)) u_quant (
    .source (source_s),
    .duty   (q_duty_s)
  );
`endif

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_r <= WAIT_FIRST;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: the first boundary load starts output; there is no way back except reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      WAIT_FIRST: begin
        if (load_s) begin
          state_next_s = RUN;
        end else begin
          state_next_s = WAIT_FIRST;
        end
      end
      RUN:     state_next_s = RUN;
      default: state_next_s = WAIT_FIRST;
    endcase
  end

  // FSM output: compare against next-cycle values so the registered edge lines up with cnt.
  always_comb begin
    pwm_next_s = 1'b0;
    if ((state_next_s == RUN) && (cnt_next_s < duty_next_s)) begin
      pwm_next_s = 1'b1;
    end else begin
      pwm_next_s = 1'b0;
    end
  end

  // Counter, duty buffer, pending sample and status flags.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      cnt_r          <= {PWM_BITS{1'b0}};
      duty_r         <= DUTY_MID;
      pend_r         <= {SAMPLE_W{1'b0}};
      pend_vld_r     <= 1'b0;
      pwm_r          <= 1'b0;
      sample_taken_r <= 1'b0;
      overrun_r      <= 1'b0;
    end else begin
      cnt_r          <= cnt_next_s;
      duty_r         <= duty_next_s;
      pwm_r          <= pwm_next_s;
      sample_taken_r <= load_s;
      if (load_s) begin
        pend_vld_r <= 1'b0;
      end else if (data_valid_in) begin
        pend_r     <= data_in;
        pend_vld_r <= 1'b1;
        if (pend_vld_r) begin
          overrun_r <= 1'b1;
        end
      end
    end
  end

  assign pwm_out          = pwm_r;
  assign sample_taken_out = sample_taken_r;
  assign overrun_out      = overrun_r;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Self-checking bench for audio_pwm_out: directed scenarios plus randomized strobes,
// compared each cycle against a period/phase reference model.
module tb_audio_pwm_out;
  localparam int PWM_BITS = 8;
  localparam int P        = 2 ** PWM_BITS;
  localparam int DIV      = 2 ** (16 - PWM_BITS);

  logic        clk_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic        data_valid_in = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        pwm_out, sample_taken_out, overrun_out;

  int checks = 0;
  int errors = 0;
  int hi_acc = 0;
  int taken_acc = 0;

  // reference model: position within the PWM period plus buffered sample state
  int          m_phase = 0;
  int          m_duty = P / 2;
  int          m_err = 0;
  logic [15:0] m_pend = 16'h0000;
  bit          m_pend_vld = 1'b0;
  bit          m_run = 1'b0;
  bit          m_pwm = 1'b0;
  bit          m_taken = 1'b0;
  bit          m_ovr = 1'b0;

  int exp_ns[8];

  audio_pwm_out #(.PWM_BITS(PWM_BITS)) dut (
    .clk_in           (clk_in),
    .reset_n_in       (reset_n_in),
    .data_in          (data_in),
    .data_valid_in    (data_valid_in),
    .pwm_out          (pwm_out),
    .sample_taken_out (sample_taken_out),
    .overrun_out      (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic quantise(input logic [15:0] s);
    int ob;
`ifdef PWM_NOISE_SHAPE_EN
    int sum;
`endif
    ob = int'(s ^ 16'h8000);
`ifdef PWM_NOISE_SHAPE_EN
    sum    = ob + m_err;
    m_err  = sum % DIV;
    m_duty = (sum >= 65536) ? P - 1 : sum / DIV;
`else
    m_duty = ob / DIV;
`endif
  endtask

  task automatic model_step(input logic rn, input logic dv, input logic [15:0] d);
    bit ld;
    if (!rn) begin
      m_phase = 0; m_duty = P / 2; m_err = 0; m_pend_vld = 1'b0;
      m_run = 1'b0; m_pwm = 1'b0; m_taken = 1'b0; m_ovr = 1'b0;
    end else begin
      ld      = (m_phase == P - 1) && (m_pend_vld || dv);
      m_taken = ld;
      if (ld) begin
        quantise(dv ? d : m_pend);
        m_run      = 1'b1;
        m_pend_vld = 1'b0;
      end else if (dv) begin
        if (m_pend_vld) m_ovr = 1'b1;
        m_pend     = d;
        m_pend_vld = 1'b1;
      end
      m_phase = (m_phase + 1) % P;
      m_pwm   = m_run && (m_phase < m_duty);
    end
  endtask

  // one clock: drive inputs, advance the model at the edge, compare just after it
  task automatic cyc(input logic rn, input logic dv, input logic [15:0] d);
    reset_n_in    = rn;
    data_valid_in = dv;
    data_in       = d;
    @(posedge clk_in);
    model_step(rn, dv, d);
    #1;
    chk("pwm", pwm_out, m_pwm);
    chk("taken", sample_taken_out, m_taken);
    chk("overrun", overrun_out, m_ovr);
    hi_acc    += int'(pwm_out);
    taken_acc += int'(sample_taken_out);
  endtask

  task automatic idle_until(input int p);
    while (m_phase != p) cyc(1'b1, 1'b0, 16'h0000);
  endtask

  // count high clocks over one full period starting with the current sample
  task automatic measure(input string tag, input int exp_hi);
    hi_acc = int'(pwm_out);
    repeat (P - 1) cyc(1'b1, 1'b0, 16'h0000);
    chk(tag, hi_acc, exp_hi);
  endtask

  task automatic load_measure(input string tag, input int at, input logic [15:0] d, input int exp_hi);
    idle_until(at);
    cyc(1'b1, 1'b1, d);
    if (at != P - 1) begin
      idle_until(P - 1);
      cyc(1'b1, 1'b0, 16'h0000);
    end
    chk({tag, "_taken"}, sample_taken_out, 1'b1);
    measure({tag, "_hi"}, exp_hi);
  endtask

  initial begin
    // 1: reset then a long idle stretch with no samples
    repeat (3) cyc(1'b0, 1'b0, 16'h0000);
    chk("rst_pwm", pwm_out, 1'b0);
    chk("rst_ovr", overrun_out, 1'b0);
    hi_acc = 0; taken_acc = 0;
    repeat (1000) cyc(1'b1, 1'b0, 16'h0000);
    chk("idle_hi", hi_acc, 0);
    chk("idle_taken", taken_acc, 0);
    chk("idle_ovr", overrun_out, 1'b0);

    // 2: midscale, 3: extremes
    load_measure("mid", 10, 16'h0000, 128);
    load_measure("min", 30, 16'h8000, 0);
    load_measure("max", 30, 16'h7FFF, 255);

    // pending sample replaced by a strobe on the boundary: bypass, no overrun
    idle_until(50);
    cyc(1'b1, 1'b1, 16'h1000);
    idle_until(P - 1);
    cyc(1'b1, 1'b1, 16'h4000);
    chk("byp_taken", sample_taken_out, 1'b1);
    chk("byp_ovr", overrun_out, 1'b0);
    measure("byp_hi", 192);

    // 4: two strobes in one period -> sticky overrun, newest sample wins
    idle_until(20);
    cyc(1'b1, 1'b1, 16'h1000);
    idle_until(40);
    cyc(1'b1, 1'b1, 16'hF000);
    chk("ovr_set", overrun_out, 1'b1);
    idle_until(P - 1);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("ovr_taken", sample_taken_out, 1'b1);
    measure("ovr_hi", 112);
    chk("ovr_sticky", overrun_out, 1'b1);

    // 5: reset mid-period while running at duty C0
    load_measure("pre_rst", 30, 16'h4000, 192);
    idle_until(100);
    cyc(1'b0, 1'b0, 16'h0000);
    chk("mid_rst_pwm", pwm_out, 1'b0);
    chk("mid_rst_ovr", overrun_out, 1'b0);
    chk("mid_rst_taken", sample_taken_out, 1'b0);
    hi_acc = 0;
    repeat (300) cyc(1'b1, 1'b0, 16'h0000);
    chk("post_rst_hi", hi_acc, 0);
    load_measure("post_rst", 10, 16'h0000, 128);

    // 6: repeated small offset; error feedback dithers the LSB
    cyc(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
`ifdef PWM_NOISE_SHAPE_EN
      exp_ns[i] = ((i % 4) == 3) ? 129 : 128;
`else
      exp_ns[i] = 128;
`endif
      load_measure($sformatf("ns%0d", i), 30, 16'h0040, exp_ns[i]);
    end
    load_measure("ns_pre_sat", 30, 16'h0040, 128);
    load_measure("ns_sat", 30, 16'h7FFF, 255);

    // randomized strobes, boundary-coincident strobes and rare resets
    cyc(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 6000; i++) begin
      logic dv;
      logic rn;
      dv = ($urandom_range(0, 149) == 0) ||
           ((m_phase == P - 1) && ($urandom_range(0, 2) == 0));
      rn = ($urandom_range(0, 2499) != 0);
      cyc(rn, dv, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
